event_packetizer: RTL and testbench

Downstream stage of the pixel-level arbiter. It takes each granted pixel event (row/column address plus polarity), stamps it with a free-running timestamp, and packs it into an event word. Event words are buffered in a synchronous FIFO and presented on a valid/ready output toward the readout interface. When the timestamp wraps, the block inserts an epoch marker word. When the FIFO fills, it back-pressures the arbiter, and it counts any events that are dropped.

---
 rtl/event_packetizer.sv | 167 ++++++++++++++++
 tb/tb_event_packetizer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_packetizer.sv
// event_packetizer: stamps granted pixel events with a free-running timestamp,
// packs them into event words, inserts an epoch marker on every timestamp wrap,
// and buffers the words in a FIFO toward a valid/ready readout port.
module event_packetizer #(
    parameter int ADD_W      = 4,
    parameter int TS_W       = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W     = 8,
    localparam int WORD_W    = 3 + 2 * ADD_W + TS_W,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              evt_valid_i,
    input  logic [ADD_W-1:0]  x_add_i,
    input  logic [ADD_W-1:0]  y_add_i,
    input  logic              pol_i,
    output logic              evt_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WORD_W-1:0] data_o,
    output logic [CNT_W-1:0]  level_o,
    output logic [DROP_W-1:0] drop_cnt_o,
    output logic              overflow_o
);

    localparam int AW = CNT_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MARK = 2'd2
    } state_t;

    state_t            state_q;
    logic [TS_W-1:0]   ts_q;
    logic [TS_W-1:0]   epoch_q;
    logic [CNT_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  wr_ptr_nx;
    logic [CNT_W-1:0]  rd_ptr_nx;
    logic [CNT_W-1:0]  level;
    logic [CNT_W-1:0]  level_nx;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [WORD_W-1:0] data_q;
    logic [WORD_W-1:0] wr_word;
    logic [DROP_W-1:0] drop_q;
    logic              ovf_q;
    logic              full;
    logic              empty;
    logic              marker_pend;
    logic              wrap;
    logic              marker_wr;
    logic              evt_acc;
    logic              evt_drop;
    logic              wr_en;
    logic              rd_en;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

    function automatic logic [WORD_W-1:0] pack_event(input logic p,
                                                      input logic [ADD_W-1:0] x,
                                                      input logic [ADD_W-1:0] y,
                                                      input logic [TS_W-1:0] ts);
        return {2'b01, p, x, y, ts};
    endfunction

    function automatic logic [WORD_W-1:0] pack_marker(input logic [TS_W-1:0] ep);
        return {2'b10, {(1 + 2 * ADD_W){1'b0}}, ep};
    endfunction

    // A pending marker is exactly the MARK state; it blocks events until written.
    assign marker_pend = (state_q == MARK);
    assign level       = wr_ptr_q - rd_ptr_q;
    assign full        = (level == CNT_W'(FIFO_DEPTH));
    assign empty       = (level == '0);
    assign wrap        = enable_i && (ts_q == {TS_W{1'b1}});

    assign evt_ready_o = enable_i & ~full & ~marker_pend;
    assign marker_wr   = enable_i & marker_pend & ~full;
    assign evt_acc     = evt_valid_i & evt_ready_o;
    assign evt_drop    = enable_i & evt_valid_i & ~evt_ready_o;
    assign wr_en       = marker_wr | evt_acc;
    assign rd_en       = ~empty & out_ready_i;

    // Marker and event never compete: a pending marker holds evt_ready_o low.
    assign wr_word   = marker_wr ? pack_marker(epoch_q)
                                 : pack_event(pol_i, x_add_i, y_add_i, ts_q);
    assign wr_ptr_nx = wr_ptr_q + CNT_W'(wr_en);
    assign rd_ptr_nx = rd_ptr_q + CNT_W'(rd_en);
    assign level_nx  = wr_ptr_nx - rd_ptr_nx;

    assign out_valid_o = ~empty;
    assign level_o     = level;
    assign data_o      = data_q;
    assign drop_cnt_o  = drop_q;
    assign overflow_o  = ovf_q;

    // Timestamp, epoch and capture state machine (IDLE/RUN/MARK).
    always_ff @(posedge clk_i) begin
        if (!reset_i || !enable_i) begin
            ts_q    <= '0;
            epoch_q <= '0;
            state_q <= IDLE;
        end else begin
            ts_q <= ts_q + 1'b1;
            if (wrap) begin
                epoch_q <= epoch_q + 1'b1;
            end
            case (state_q)
                IDLE:    state_q <= wrap ? MARK : RUN;
                RUN:     if (wrap) state_q <= MARK;
                // A wrap on the marker's own write edge re-arms the marker.
                MARK:    if (marker_wr && !wrap) state_q <= RUN;
                default: state_q <= IDLE;
            endcase
        end
    end

    // FIFO read/write pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_nx;
            rd_ptr_q <= rd_ptr_nx;
        end
    end

    // FIFO storage, written without reset since pointers gate every read.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_word;
        end
    end

    // Registered head word; a write into an empty slot at the head is bypassed
    // so it appears one cycle after acceptance, and the word holds when empty.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            data_q <= '0;
        end else if (level_nx != '0) begin
            if (wr_en && (wr_ptr_q[AW-1:0] == rd_ptr_nx[AW-1:0])) begin
                data_q <= wr_word;
            end else begin
                data_q <= mem[rd_ptr_nx[AW-1:0]];
            end
        end
    end

    // Drop counter and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else if (evt_drop) begin
            drop_q <= sat_inc(drop_q);
            ovf_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_event_packetizer.sv
// Testbench for event_packetizer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_event_packetizer;

    localparam int ADD_W      = 4;
    localparam int TS_W       = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int DROP_W     = 8;
    localparam int WORD_W     = 3 + 2 * ADD_W + TS_W;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int TS_MAX     = (1 << TS_W) - 1;
    localparam int DROP_MAX   = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              reset_i = 1'b0;
    logic              enable_i = 1'b0;
    logic              evt_valid_i = 1'b0;
    logic [ADD_W-1:0]  x_add_i = '0;
    logic [ADD_W-1:0]  y_add_i = '0;
    logic              pol_i = 1'b0;
    logic              out_ready_i = 1'b0;
    logic              evt_ready_o;
    logic              out_valid_o;
    logic [WORD_W-1:0] data_o;
    logic [CNT_W-1:0]  level_o;
    logic [DROP_W-1:0] drop_cnt_o;
    logic              overflow_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int                m_ts   = 0;
    int                m_ep   = 0;
    bit                m_pend = 0;
    int                m_drop = 0;
    bit                m_ovf  = 0;
    logic [WORD_W-1:0] m_q[$];

    // Observed output stream and ready-low counter
    logic [WORD_W-1:0] seen[$];
    int                rdy_low = 0;
    logic [WORD_W-1:0] exp_w[10];

    event_packetizer #(
        .ADD_W(ADD_W), .TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH), .DROP_W(DROP_W)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
        .evt_valid_i(evt_valid_i), .x_add_i(x_add_i), .y_add_i(y_add_i),
        .pol_i(pol_i), .evt_ready_o(evt_ready_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .data_o(data_o), .level_o(level_o),
        .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] mk_evt(input logic p, input logic [ADD_W-1:0] x,
                                                  input logic [ADD_W-1:0] y, input int ts);
        return {2'b01, p, x, y, TS_W'(ts)};
    endfunction

    function automatic logic [WORD_W-1:0] mk_mark(input int ep);
        return {2'b10, {(1 + 2 * ADD_W){1'b0}}, TS_W'(ep)};
    endfunction

    function automatic logic [WORD_W-1:0] seen_at(input int i);
        if (i < seen.size()) return seen[i];
        return 'x;
    endfunction

    // Sample outputs mid-cycle and compare against the model.
    task automatic chk_now();
        int sz;
        @(negedge clk);
        sz = m_q.size();
        check("evt_ready", evt_ready_o, enable_i && (sz < FIFO_DEPTH) && !m_pend);
        check("out_valid", out_valid_o, sz > 0);
        check("level", level_o, sz);
        if (sz > 0) check("data", data_o, m_q[0]);
        check("drop_cnt", drop_cnt_o, m_drop);
        check("overflow", overflow_o, m_ovf);
        if (!evt_ready_o) rdy_low++;
        if (out_valid_o && out_ready_i) seen.push_back(data_o);
    endtask

    // Advance one clock edge, applying the behavioural rules to the model.
    task automatic adv();
        int sz;
        bit full, rdy, rd;
        sz   = m_q.size();
        full = (sz == FIFO_DEPTH);
        rdy  = enable_i && !full && !m_pend;
        rd   = (sz > 0) && out_ready_i;
        @(posedge clk);
        if (!reset_i) begin
            m_q.delete();
            m_ts = 0; m_ep = 0; m_pend = 0; m_drop = 0; m_ovf = 0;
        end else begin
            if (rd) m_q.delete(0);
            if (enable_i) begin
                if (m_pend && !full) begin
                    m_q.push_back(mk_mark(m_ep));
                    m_pend = 0;
                end else if (evt_valid_i && rdy) begin
                    m_q.push_back(mk_evt(pol_i, x_add_i, y_add_i, m_ts));
                end
                if (evt_valid_i && !rdy) begin
                    if (m_drop < DROP_MAX) m_drop++;
                    m_ovf = 1;
                end
                if (m_ts == TS_MAX) begin
                    m_ts = 0;
                    m_ep = (m_ep + 1) % (1 << TS_W);
                    m_pend = 1;
                end else begin
                    m_ts++;
                end
            end else begin
                m_ts = 0; m_ep = 0; m_pend = 0;
            end
        end
        #1;
    endtask

    task automatic cycle();
        chk_now();
        adv();
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        cycle();
        reset_i = 1'b1;
    endtask

    task automatic send(input logic p, input logic [ADD_W-1:0] x, input logic [ADD_W-1:0] y);
        evt_valid_i = 1'b1; pol_i = p; x_add_i = x; y_add_i = y;
    endtask

    initial begin
        // Reset with other inputs active
        enable_i = 1'b1; out_ready_i = 1'b1; send(1'b1, 4'hA, 4'hB);
        repeat (2) begin @(posedge clk); #1; end
        reset_i = 1'b1;
        chk_now();
        check("rst_level", level_o, 0);
        check("rst_valid", out_valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_drop", drop_cnt_o, 0);
        check("rst_ovf", overflow_o, 0);
        adv();
        evt_valid_i = 1'b0;

        // Single event at ts=6, one-cycle latency
        enable_i = 1'b0;
        repeat (2) cycle();
        enable_i = 1'b1;
        for (int i = 0; i < 20 && m_ts != 6; i++) cycle();
        send(1'b1, 4'h3, 4'h5);
        cycle();
        evt_valid_i = 1'b0;
        chk_now();
        check("t1_valid", out_valid_o, 1);
        check("t1_data", data_o, 15'h3356);
        adv();
        chk_now();
        check("t1_valid_off", out_valid_o, 0);
        adv();

        // Wrap: event at ts=15, marker, event at ts=1
        enable_i = 1'b0;
        repeat (2) cycle();
        enable_i = 1'b1;
        for (int i = 0; i < 20 && m_ts != TS_MAX; i++) cycle();
        seen.delete(); rdy_low = 0;
        send(1'b0, 4'h2, 4'h7);
        cycle();
        evt_valid_i = 1'b0;
        cycle();
        send(1'b1, 4'h9, 4'h1);
        cycle();
        evt_valid_i = 1'b0;
        repeat (4) cycle();
        check("t2_count", seen.size(), 3);
        check("t2_evt15", seen_at(0), 15'h227F);
        check("t2_marker", seen_at(1), 15'h4001);
        check("t2_evt1", seen_at(2), 15'h3911);
        check("t2_ready_low", rdy_low, 1);

        // Overfill: 10 events into an 8-deep FIFO with no reads
        do_reset();
        enable_i = 1'b1; out_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(1'($urandom), 4'($urandom), 4'($urandom));
            exp_w[i] = mk_evt(pol_i, x_add_i, y_add_i, i);
            cycle();
        end
        evt_valid_i = 1'b0;
        chk_now();
        check("t3_level", level_o, 8);
        check("t3_drop", drop_cnt_o, 2);
        check("t3_ovf", overflow_o, 1);
        adv();
        seen.delete(); out_ready_i = 1'b1;
        repeat (10) cycle();
        for (int i = 0; i < 8; i++) check("t3_order", seen_at(i), exp_w[i]);

        // Full FIFO held across three wraps: one marker with epoch 3
        do_reset();
        enable_i = 1'b1; out_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(1'($urandom), 4'($urandom), 4'($urandom));
            exp_w[i] = mk_evt(pol_i, x_add_i, y_add_i, i);
            cycle();
        end
        evt_valid_i = 1'b0;
        for (int i = 0; i < 100 && m_ep != 3; i++) cycle();
        repeat (2) cycle();
        seen.delete(); out_ready_i = 1'b1;
        repeat (10) cycle();
        check("t4_count", seen.size(), 9);
        for (int i = 0; i < 8; i++) check("t4_order", seen_at(i), exp_w[i]);
        check("t4_marker", seen_at(8), 15'h4003);

        // Disable with 4 queued words: drain, no writes, restart at ts=0
        do_reset();
        enable_i = 1'b1; out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1'($urandom), 4'($urandom), 4'($urandom));
            exp_w[i] = mk_evt(pol_i, x_add_i, y_add_i, i);
            cycle();
        end
        enable_i = 1'b0; seen.delete();
        for (int i = 0; i < 10; i++) begin
            out_ready_i = (i >= 2);
            send(1'($urandom), 4'($urandom), 4'($urandom));
            cycle();
        end
        check("t5_count", seen.size(), 4);
        for (int i = 0; i < 4; i++) check("t5_order", seen_at(i), exp_w[i]);
        check("t5_level", level_o, 0);
        check("t5_drop_hold", drop_cnt_o, 0);
        seen.delete();
        enable_i = 1'b1;
        send(1'b1, 4'hC, 4'h3);
        cycle();
        evt_valid_i = 1'b0;
        repeat (20) cycle();
        check("t5_ts0", seen_at(0), 15'h3C30);
        check("t5_epoch1", seen_at(1), 15'h4001);

        // Drop counter saturation
        do_reset();
        enable_i = 1'b1; out_ready_i = 1'b0;
        send(1'b0, 4'h1, 4'h1);
        repeat (280) cycle();
        evt_valid_i = 1'b0;
        chk_now();
        check("t6_drop_sat", drop_cnt_o, DROP_MAX);
        check("t6_ovf", overflow_o, 1);
        adv();

        // Randomized traffic with occasional resets and disables
        for (int i = 0; i < 1500; i++) begin
            reset_i     = ($urandom_range(0, 199) != 0);
            enable_i    = ($urandom_range(0, 15) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            evt_valid_i = 1'($urandom);
            pol_i       = 1'($urandom);
            x_add_i     = 4'($urandom);
            y_add_i     = 4'($urandom);
            cycle();
        end
        reset_i = 1'b1; evt_valid_i = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
